// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: request-to-send, one byte LSB first with odd parity,
// then device acknowledge check. Status is read back over the 32-bit port bus.
module ps2_host_tx #(
    parameter int INHIBIT_CYCLES = 5000,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic        clkCPU,
    input  logic        reset,
    inout  wire  [31:0] data,
    input  logic        read,
    input  logic        write,
    output logic        interupt,
    inout  wire         psclk,
    inout  wire         psdata,
    output logic        txActive
);

    localparam int IW = $clog2(INHIBIT_CYCLES + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [IW-1:0] INHIBIT_LAST = IW'(INHIBIT_CYCLES - 1);
    localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE, INHIBIT, REQ, SEND, ACK, WAITIDLE, DONE
    } stateT;

    stateT state, nextState;

    logic [1:0]    clkSync, dataSync;
    logic          clkPrev;
    logic          fallEdge;
    logic [IW-1:0] inhibitCnt;
    logic [TW-1:0] timeoutCnt;
    logic [3:0]    bitCnt;
    logic [9:0]    shiftReg;
    logic [7:0]    lastByte;
    logic          psdataLow;
    logic          doneFlag, errorFlag;
    logic          busy;
    logic          timedOut;
    logic          finish;
    logic          unusedDataHigh;

    assign unusedDataHigh = ^data[31:8];

    assign fallEdge = clkPrev & ~clkSync[1];
    assign busy     = (state != IDLE);
    assign txActive = busy;
    assign psclk    = (state == INHIBIT || state == REQ) ? 1'b0 : 1'bz;
    assign psdata   = psdataLow ? 1'b0 : 1'bz;
    assign data     = read ? {16'h0000, lastByte, 5'b00000, errorFlag, doneFlag, busy} : 32'bz;

    // Synchronizers idle high so leaving reset never looks like a clock edge.
    always_ff @(posedge clkCPU) begin
        if (reset) begin
            clkSync  <= 2'b11;
            dataSync <= 2'b11;
            clkPrev  <= 1'b1;
        end else begin
            clkSync  <= {clkSync[0], psclk};
            dataSync <= {dataSync[0], psdata};
            clkPrev  <= clkSync[1];
        end
    end

    always_comb begin
        nextState = state;
        timedOut  = 1'b0;
        case (state)
            IDLE:     if (write) nextState = INHIBIT;
            INHIBIT:  if (inhibitCnt == INHIBIT_LAST) nextState = REQ;
            REQ:      nextState = SEND;
            SEND:     if (fallEdge && bitCnt == 4'd9) nextState = ACK;
            ACK:      if (fallEdge) nextState = WAITIDLE;
            WAITIDLE: if (clkSync[1] && dataSync[1]) nextState = DONE;
            DONE:     nextState = IDLE;
            default:  nextState = IDLE;
        endcase
        // A falling edge in the same cycle always beats the timeout.
        if ((state == SEND || state == ACK || state == WAITIDLE) &&
            !fallEdge && timeoutCnt == TIMEOUT_LAST) begin
            timedOut  = 1'b1;
            nextState = IDLE;
        end
        finish = (nextState == DONE) || timedOut;
    end

    always_ff @(posedge clkCPU) begin
        if (reset) begin
            state      <= IDLE;
            inhibitCnt <= '0;
            timeoutCnt <= '0;
            bitCnt     <= '0;
            shiftReg   <= '0;
            lastByte   <= '0;
            psdataLow  <= 1'b0;
            doneFlag   <= 1'b0;
            errorFlag  <= 1'b0;
            interupt   <= 1'b0;
        end else begin
            state    <= nextState;
            interupt <= finish;

            inhibitCnt <= (state == INHIBIT) ? inhibitCnt + IW'(1) : '0;

            if (state == IDLE || state == INHIBIT || state == REQ || fallEdge)
                timeoutCnt <= '0;
            else
                timeoutCnt <= timeoutCnt + TW'(1);

            if (read) begin
                doneFlag  <= 1'b0;
                errorFlag <= 1'b0;
            end

            if (state == IDLE && write) begin
                lastByte  <= data[7:0];
                shiftReg  <= {1'b1, ~^data[7:0], data[7:0]};
                doneFlag  <= 1'b0;
                errorFlag <= 1'b0;
            end

            if (state == INHIBIT && nextState == REQ)
                psdataLow <= 1'b1;

            if (state == REQ)
                bitCnt <= '0;

            // Frame is D0..D7, parity, stop; the stop bit is a 1 so the line is released.
            if (state == SEND && fallEdge) begin
                psdataLow <= ~shiftReg[0];
                shiftReg  <= {1'b1, shiftReg[9:1]};
                bitCnt    <= bitCnt + 4'd1;
            end

            if (state == ACK && fallEdge && dataSync[1])
                errorFlag <= 1'b1;

            if (nextState == DONE)
                doneFlag <= 1'b1;

            if (timedOut) begin
                psdataLow <= 1'b0;
                doneFlag  <= 1'b1;
                errorFlag <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Self-checking bench for ps2_host_tx: a PS/2 device model clocks the frame out,
// and every captured frame and status word is compared against a reference model.
module tb_ps2_host_tx;

    localparam int INHIBIT = 20;
    localparam int TIMEOUT = 200;
    localparam int HALF    = 6;

    logic        clkCPU = 1'b0;
    logic        reset  = 1'b1;
    logic        read   = 1'b0;
    logic        write  = 1'b0;
    logic        cpuDrive = 1'b0;
    logic [31:0] cpuData  = 32'h0;
    logic        devClk   = 1'b0;
    logic        devData  = 1'b0;
    wire  [31:0] data;
    wire         psclk;
    wire         psdata;
    logic        interupt;
    logic        txActive;

    int testsRun    = 0;
    int testsFailed = 0;
    int cycleCnt    = 0;
    int intCount    = 0;
    int intCycle    = 0;
    int lastFallCycle = 0;

    pullup (psclk);
    pullup (psdata);
    assign psclk  = devClk  ? 1'b0 : 1'bz;
    assign psdata = devData ? 1'b0 : 1'bz;
    assign data   = cpuDrive ? cpuData : 32'bz;

    ps2_host_tx #(.INHIBIT_CYCLES(INHIBIT), .TIMEOUT_CYCLES(TIMEOUT)) dut (
        .clkCPU(clkCPU), .reset(reset), .data(data), .read(read), .write(write),
        .interupt(interupt), .psclk(psclk), .psdata(psdata), .txActive(txActive)
    );

    always #5 clkCPU = ~clkCPU;

    always @(posedge clkCPU) cycleCnt <= cycleCnt + 1;

    always @(negedge clkCPU) begin
        if (interupt === 1'b1) begin
            intCount <= intCount + 1;
            intCycle <= cycleCnt;
        end
    end

    // Reference frame as the device should see it: data LSB first, odd parity, stop high.
    function automatic logic [9:0] expectedFrame(input logic [7:0] b);
        logic par;
        par = ($countones(b) % 2) == 0;
        return {1'b1, par, b};
    endfunction

    task automatic cpuWrite(input logic [7:0] b);
        @(posedge clkCPU); #1;
        write = 1'b1; cpuDrive = 1'b1; cpuData = {24'h0, b};
        @(posedge clkCPU); #1;
        write = 1'b0; cpuDrive = 1'b0;
    endtask

    task automatic cpuRead(output logic [31:0] w);
        @(posedge clkCPU); #1;
        read = 1'b1;
        @(negedge clkCPU);
        w = data;
        @(posedge clkCPU); #1;
        read = 1'b0;
    endtask

    // Device side: waits for the request-to-send, then generates nPulses clocks,
    // sampling psdata just before each rising edge. Pulse 11 carries the ack.
    task automatic runDevice(input int nPulses, input bit doAck,
                             output logic [9:0] bits, output bit reqSeen);
        int guard;
        bits = '1;
        reqSeen = 1'b0;
        guard = 0;
        while (!(psclk === 1'b1 && psdata === 1'b0) && guard < 1000) begin
            @(negedge clkCPU);
            guard++;
        end
        if (guard < 1000) begin
            reqSeen = 1'b1;
            repeat (HALF) @(negedge clkCPU);
            for (int k = 1; k <= nPulses; k++) begin
                if (k == 11 && doAck) begin
                    devData = 1'b1;
                    repeat (2) @(negedge clkCPU);
                end
                devClk = 1'b1;
                lastFallCycle = cycleCnt;
                repeat (HALF) @(negedge clkCPU);
                if (k <= 10) bits[k-1] = psdata;
                devClk = 1'b0;
                repeat (HALF) @(negedge clkCPU);
                devData = 1'b0;
            end
        end
    endtask

    task automatic waitIntr(input int startCount, input int budget, output bit seen);
        seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            @(negedge clkCPU); #1;
            if (intCount != startCount) seen = 1'b1;
        end
    endtask

    task automatic test_reset;
        logic [31:0] w;
        reset = 1'b1;
        repeat (3) @(posedge clkCPU);
        #1 reset = 1'b0;
        @(negedge clkCPU);
        testsRun++; if (interupt !== 1'b0) begin testsFailed++; $display("[TB] FAIL reset_interupt got %b want 0", interupt); end
        testsRun++; if (txActive !== 1'b0) begin testsFailed++; $display("[TB] FAIL reset_txActive got %b want 0", txActive); end
        testsRun++; if (psclk !== 1'b1) begin testsFailed++; $display("[TB] FAIL reset_psclk got %b want released", psclk); end
        testsRun++; if (psdata !== 1'b1) begin testsFailed++; $display("[TB] FAIL reset_psdata got %b want released", psdata); end
        cpuRead(w);
        testsRun++; if (w !== 32'h0) begin testsFailed++; $display("[TB] FAIL reset_status got %h want 00000000", w); end
    endtask

    task automatic test_send_ed;
        logic [9:0] bits; bit req, seen; int startInt; logic [31:0] w;
        startInt = intCount;
        cpuWrite(8'hED);
        @(negedge clkCPU);
        testsRun++; if (txActive !== 1'b1) begin testsFailed++; $display("[TB] FAIL ed_busy got %b want 1", txActive); end
        testsRun++; if (psclk !== 1'b0) begin testsFailed++; $display("[TB] FAIL ed_inhibit got %b want 0", psclk); end
        runDevice(11, 1'b1, bits, req);
        testsRun++; if (req !== 1'b1) begin testsFailed++; $display("[TB] FAIL ed_request got %b want 1", req); end
        testsRun++; if (bits !== expectedFrame(8'hED)) begin testsFailed++; $display("[TB] FAIL ed_frame got %b want %b", bits, expectedFrame(8'hED)); end
        waitIntr(startInt, 100, seen);
        repeat (3) @(negedge clkCPU);
        testsRun++; if (intCount !== startInt + 1) begin testsFailed++; $display("[TB] FAIL ed_interupt got %0d pulses want 1", intCount - startInt); end
        cpuRead(w);
        testsRun++; if (w !== 32'h0000ED02) begin testsFailed++; $display("[TB] FAIL ed_status got %h want 0000ED02", w); end
        cpuRead(w);
        testsRun++; if (w !== 32'h0000ED00) begin testsFailed++; $display("[TB] FAIL ed_flag_clear got %h want 0000ED00", w); end
    endtask

    task automatic test_inhibit;
        logic [7:0] b; logic [9:0] bits; bit req, seen; int startInt, lowCycles, dataLowAt; logic [31:0] w;
        b = 8'($urandom_range(0, 255));
        startInt = intCount;
        @(posedge clkCPU); #1;
        write = 1'b1; cpuDrive = 1'b1; cpuData = {24'h0, b};
        @(posedge clkCPU); #1;
        write = 1'b0; cpuDrive = 1'b0;
        lowCycles = 0;
        dataLowAt = -1;
        while (lowCycles < 1000) begin
            @(negedge clkCPU);
            if (psclk !== 1'b0) break;
            if (psdata === 1'b0 && dataLowAt < 0) dataLowAt = lowCycles;
            lowCycles++;
        end
        testsRun++; if (lowCycles !== INHIBIT + 1) begin testsFailed++; $display("[TB] FAIL inhibit_len got %0d want %0d", lowCycles, INHIBIT + 1); end
        testsRun++; if (dataLowAt !== INHIBIT) begin testsFailed++; $display("[TB] FAIL start_bit_at got %0d want %0d", dataLowAt, INHIBIT); end
        runDevice(11, 1'b1, bits, req);
        testsRun++; if (bits !== expectedFrame(b)) begin testsFailed++; $display("[TB] FAIL inhibit_frame got %b want %b", bits, expectedFrame(b)); end
        waitIntr(startInt, 100, seen);
        testsRun++; if (seen !== 1'b1) begin testsFailed++; $display("[TB] FAIL inhibit_done got %b want 1", seen); end
        cpuRead(w);
        testsRun++; if (w !== {16'h0, b, 8'h02}) begin testsFailed++; $display("[TB] FAIL inhibit_status got %h want %h", w, {16'h0, b, 8'h02}); end
    endtask

    task automatic test_random_bytes;
        logic [7:0] b; logic [9:0] bits; bit req, seen; int startInt; logic [31:0] w;
        for (int n = 0; n < 3; n++) begin
            b = 8'($urandom_range(0, 255));
            startInt = intCount;
            cpuWrite(b);
            runDevice(11, 1'b1, bits, req);
            testsRun++; if (bits !== expectedFrame(b)) begin testsFailed++; $display("[TB] FAIL rand_frame byte %h got %b want %b", b, bits, expectedFrame(b)); end
            waitIntr(startInt, 100, seen);
            testsRun++; if (seen !== 1'b1) begin testsFailed++; $display("[TB] FAIL rand_done byte %h got %b want 1", b, seen); end
            cpuRead(w);
            testsRun++; if (w !== {16'h0, b, 8'h02}) begin testsFailed++; $display("[TB] FAIL rand_status got %h want %h", w, {16'h0, b, 8'h02}); end
        end
    endtask

    task automatic test_no_ack;
        logic [7:0] b; logic [9:0] bits; bit req, seen; int startInt; logic [31:0] w;
        b = 8'($urandom_range(0, 255));
        startInt = intCount;
        cpuWrite(b);
        runDevice(11, 1'b0, bits, req);
        testsRun++; if (bits !== expectedFrame(b)) begin testsFailed++; $display("[TB] FAIL noack_frame got %b want %b", bits, expectedFrame(b)); end
        waitIntr(startInt, 100, seen);
        repeat (3) @(negedge clkCPU);
        testsRun++; if (intCount !== startInt + 1) begin testsFailed++; $display("[TB] FAIL noack_interupt got %0d pulses want 1", intCount - startInt); end
        cpuRead(w);
        testsRun++; if (w !== {16'h0, b, 8'h06}) begin testsFailed++; $display("[TB] FAIL noack_status got %h want %h", w, {16'h0, b, 8'h06}); end
        cpuRead(w);
        testsRun++; if (w !== {16'h0, b, 8'h00}) begin testsFailed++; $display("[TB] FAIL noack_clear got %h want %h", w, {16'h0, b, 8'h00}); end
    endtask

    task automatic test_timeout;
        logic [7:0] b; logic [9:0] bits; logic [9:0] want; bit req, seen; int startInt, latency; logic [31:0] w;
        b = 8'($urandom_range(0, 255));
        want = expectedFrame(b);
        startInt = intCount;
        cpuWrite(b);
        runDevice(4, 1'b0, bits, req);
        testsRun++; if (bits[3:0] !== want[3:0]) begin testsFailed++; $display("[TB] FAIL timeout_bits got %b want %b", bits[3:0], want[3:0]); end
        waitIntr(startInt, TIMEOUT + 100, seen);
        testsRun++; if (seen !== 1'b1) begin testsFailed++; $display("[TB] FAIL timeout_interupt got %b want 1", seen); end
        latency = intCycle - lastFallCycle;
        testsRun++; if (latency < TIMEOUT || latency > TIMEOUT + 5) begin testsFailed++; $display("[TB] FAIL timeout_latency got %0d want %0d..%0d", latency, TIMEOUT, TIMEOUT + 5); end
        testsRun++; if (psclk !== 1'b1) begin testsFailed++; $display("[TB] FAIL timeout_psclk got %b want released", psclk); end
        testsRun++; if (psdata !== 1'b1) begin testsFailed++; $display("[TB] FAIL timeout_psdata got %b want released", psdata); end
        testsRun++; if (txActive !== 1'b0) begin testsFailed++; $display("[TB] FAIL timeout_txActive got %b want 0", txActive); end
        cpuRead(w);
        testsRun++; if (w !== {16'h0, b, 8'h06}) begin testsFailed++; $display("[TB] FAIL timeout_status got %h want %h", w, {16'h0, b, 8'h06}); end
    endtask

    task automatic test_back_to_back;
        logic [9:0] bits; bit req, seen; int startInt; logic [31:0] w;
        startInt = intCount;
        cpuWrite(8'hED);
        fork
            runDevice(11, 1'b1, bits, req);
            begin
                repeat (60) @(negedge clkCPU);
                cpuWrite(8'h55);
            end
        join
        testsRun++; if (bits !== expectedFrame(8'hED)) begin testsFailed++; $display("[TB] FAIL busy_write_frame got %b want %b", bits, expectedFrame(8'hED)); end
        waitIntr(startInt, 100, seen);
        repeat (3) @(negedge clkCPU);
        testsRun++; if (intCount !== startInt + 1) begin testsFailed++; $display("[TB] FAIL busy_write_interupt got %0d pulses want 1", intCount - startInt); end
        cpuRead(w);
        testsRun++; if (w !== 32'h0000ED02) begin testsFailed++; $display("[TB] FAIL busy_write_status got %h want 0000ED02", w); end
    endtask

    task automatic test_reset_mid_send;
        logic [7:0] b; logic [9:0] bits; bit req, seen; int startInt; logic [31:0] w;
        b = 8'($urandom_range(0, 255));
        startInt = intCount;
        cpuWrite(b);
        runDevice(3, 1'b0, bits, req);
        @(posedge clkCPU); #1 reset = 1'b1;
        @(posedge clkCPU);
        @(negedge clkCPU);
        testsRun++; if (psclk !== 1'b1) begin testsFailed++; $display("[TB] FAIL midreset_psclk got %b want released", psclk); end
        testsRun++; if (psdata !== 1'b1) begin testsFailed++; $display("[TB] FAIL midreset_psdata got %b want released", psdata); end
        testsRun++; if (txActive !== 1'b0) begin testsFailed++; $display("[TB] FAIL midreset_txActive got %b want 0", txActive); end
        @(posedge clkCPU); #1 reset = 1'b0;
        cpuRead(w);
        testsRun++; if (w !== 32'h0) begin testsFailed++; $display("[TB] FAIL midreset_status got %h want 00000000", w); end
        testsRun++; if (intCount !== startInt) begin testsFailed++; $display("[TB] FAIL midreset_interupt got %0d pulses want 0", intCount - startInt); end
        startInt = intCount;
        cpuWrite(8'hFF);
        runDevice(11, 1'b1, bits, req);
        testsRun++; if (bits !== expectedFrame(8'hFF)) begin testsFailed++; $display("[TB] FAIL ff_frame got %b want %b", bits, expectedFrame(8'hFF)); end
        waitIntr(startInt, 100, seen);
        cpuRead(w);
        testsRun++; if (w !== 32'h0000FF02) begin testsFailed++; $display("[TB] FAIL ff_status got %h want 0000FF02", w); end
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish, tests run %0d", testsRun);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        test_reset();
        test_send_ed();
        test_inhibit();
        test_random_bytes();
        test_no_ack();
        test_timeout();
        test_back_to_back();
        test_reset_mid_send();
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
